ttt_match_controller: RTL and testbench

Sequences the tic-tac-toe board datapath over a multi-game match. Arbitrates raw move requests from two player front-ends and issues single-cycle play strobes plus position to the board. Samples the board's illegal/winner/full status, runs a per-turn timeout, and clears the board between games. Keeps P1/P2/draw scores and declares the match winner. Sits between player input logic and the board top level.

---
 rtl/ttt_pkg.sv | 27 ++
 rtl/ttt_sat_counter.sv | 31 +++
 rtl/ttt_match_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_ttt_match_controller.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe match controller and its helpers.
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT_MOVE,
        ST_ISSUE,
        ST_CHECK,
        ST_GAME_OVER,
        ST_MATCH_OVER
    } state_e;

    localparam int              SCORE_W   = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [3:0] CELL_MAX = 4'd8;

    function automatic logic pos_ok(input logic [3:0] pos);
        return pos <= CELL_MAX;
    endfunction

endpackage

// File: rtl/ttt_sat_counter.sv
// Score-width incrementer that sticks at its maximum value; clear wins over increment.
module ttt_sat_counter import ttt_pkg::*; (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [SCORE_W-1:0] count_o
);

    logic [SCORE_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != SCORE_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ttt_match_controller.sv
// Match sequencer: arbitrates player requests, strobes moves into the board,
// tracks turn timeouts, clears the board between games and keeps the score.
module ttt_match_controller import ttt_pkg::*; #(
    parameter int WINS_TO_MATCH  = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int GAP_CYCLES     = 4,
    parameter int TMR_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               p1_req,
    input  logic [3:0]         p1_req_pos,
    input  logic               p2_req,
    input  logic [3:0]         p2_req_pos,
    output logic               p1_ack,
    output logic               p2_ack,
    output logic               p1_nack,
    output logic               p2_nack,
    output logic               board_reset,
    output logic               board_p1,
    output logic               board_p2,
    output logic [3:0]         board_pos,
    input  logic               board_illegal,
    input  logic [1:0]         board_winner,
    input  logic               board_full,
    output logic               turn,
    output logic               timeout_evt,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] draws,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [TMR_W-1:0]   TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]   GAP_LOAD     = TMR_W'(GAP_CYCLES);
    localparam logic [TMR_W-1:0]   TMR_ONE      = TMR_W'(1);
    localparam logic [SCORE_W-1:0] WINS_VAL     = SCORE_W'(WINS_TO_MATCH);
    localparam bit                 TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    state_e             state_q, state_d;
    logic               turn_q, turn_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         game_idx_q, game_idx_d;
    logic [3:0]         pos_q, pos_d;
    logic [1:0]         match_winner_q, match_winner_d;

    logic               score_clr, p1_inc, p2_inc, draw_inc;
    logic               mover_req, mover_valid, tmo_fire;
    logic [3:0]         mover_pos;

    assign mover_req   = turn_q ? p2_req : p1_req;
    assign mover_pos   = turn_q ? p2_req_pos : p1_req_pos;
    assign mover_valid = mover_req && pos_ok(mover_pos);
    // A valid move from the player on turn pre-empts a forfeit in the same cycle.
    assign tmo_fire    = TIMEOUT_EN && (state_q == ST_WAIT_MOVE) && !mover_valid
                         && (timer_q == TMR_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            turn_q         <= 1'b0;
            timer_q        <= '0;
            game_idx_q     <= '0;
            pos_q          <= '0;
            match_winner_q <= WIN_NONE;
        end else begin
            state_q        <= state_d;
            turn_q         <= turn_d;
            timer_q        <= timer_d;
            game_idx_q     <= game_idx_d;
            pos_q          <= pos_d;
            match_winner_q <= match_winner_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        turn_d         = turn_q;
        timer_d        = timer_q;
        game_idx_d     = game_idx_q;
        pos_d          = pos_q;
        match_winner_d = match_winner_q;
        score_clr      = 1'b0;
        p1_inc         = 1'b0;
        p2_inc         = 1'b0;
        draw_inc       = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_MATCH_OVER: begin
                if (start) begin
                    state_d        = ST_CLEAR;
                    score_clr      = 1'b1;
                    match_winner_d = WIN_NONE;
                    game_idx_d     = '0;
                end
            end
            ST_CLEAR: begin
                turn_d  = game_idx_q[0];
                timer_d = TIMEOUT_LOAD;
                state_d = ST_WAIT_MOVE;
            end
            ST_WAIT_MOVE: begin
                if (mover_valid) begin
                    pos_d   = mover_pos;
                    state_d = ST_ISSUE;
                end else if (tmo_fire) begin
                    turn_d  = ~turn_q;
                    timer_d = TIMEOUT_LOAD;
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_ISSUE: begin
                state_d = board_illegal ? ST_WAIT_MOVE : ST_CHECK;
            end
            ST_CHECK: begin
                if (board_winner != WIN_NONE) begin
                    p1_inc  = (board_winner == WIN_P1);
                    p2_inc  = (board_winner == WIN_P2);
                    timer_d = GAP_LOAD;
                    state_d = ST_GAME_OVER;
                end else if (board_full) begin
                    draw_inc = 1'b1;
                    timer_d  = GAP_LOAD;
                    state_d  = ST_GAME_OVER;
                end else begin
                    turn_d  = ~turn_q;
                    timer_d = TIMEOUT_LOAD;
                    state_d = ST_WAIT_MOVE;
                end
            end
            ST_GAME_OVER: begin
                if (timer_q <= TMR_ONE) begin
                    if (p1_score == WINS_VAL) begin
                        match_winner_d = WIN_P1;
                        state_d        = ST_MATCH_OVER;
                    end else if (p2_score == WINS_VAL) begin
                        match_winner_d = WIN_P2;
                        state_d        = ST_MATCH_OVER;
                    end else begin
                        game_idx_d = game_idx_q + 4'd1;
                        state_d    = ST_CLEAR;
                    end
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p1_ack      = 1'b0;
        p2_ack      = 1'b0;
        p1_nack     = 1'b0;
        p2_nack     = 1'b0;
        board_reset = 1'b0;
        board_p1    = 1'b0;
        board_p2    = 1'b0;
        board_pos   = 4'd0;
        timeout_evt = 1'b0;
        unique case (state_q)
            ST_CLEAR: board_reset = 1'b1;
            ST_WAIT_MOVE: begin
                // The waiting player is always refused; the mover only for an off-board cell.
                if (turn_q) begin
                    p1_nack = p1_req;
                    p2_nack = p2_req && !pos_ok(p2_req_pos);
                end else begin
                    p1_nack = p1_req && !pos_ok(p1_req_pos);
                    p2_nack = p2_req;
                end
                timeout_evt = tmo_fire;
            end
            ST_ISSUE: begin
                board_p1  = ~turn_q;
                board_p2  = turn_q;
                board_pos = pos_q;
                p1_ack    = ~turn_q & ~board_illegal;
                p2_ack    = turn_q & ~board_illegal;
                p1_nack   = ~turn_q & board_illegal;
                p2_nack   = turn_q & board_illegal;
            end
            ST_MATCH_OVER: begin
                p1_nack = p1_req;
                p2_nack = p2_req;
            end
            default: ;
        endcase
    end

    ttt_sat_counter u_p1_score (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (score_clr),
        .inc_i   (p1_inc),
        .count_o (p1_score)
    );

    ttt_sat_counter u_p2_score (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (score_clr),
        .inc_i   (p2_inc),
        .count_o (p2_score)
    );

    ttt_sat_counter u_draws (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (score_clr),
        .inc_i   (draw_inc),
        .count_o (draws)
    );

    assign turn         = turn_q;
    assign match_done   = (state_q == ST_MATCH_OVER);
    assign match_winner = match_winner_q;

endmodule

// File: tb/tb_ttt_match_controller.sv
// Random multi-match play against an emulated board; expected pulses and status
// come from a game-rule model and are checked by a cycle-stamped scoreboard.
module tb_ttt_match_controller;

    localparam int WINS = 2;
    localparam int TMO  = 10;
    localparam int GAP  = 4;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic       p1_req = 1'b0, p2_req = 1'b0;
    logic [3:0] p1_req_pos = 4'd0, p2_req_pos = 4'd0;
    logic       p1_ack, p2_ack, p1_nack, p2_nack, board_reset, board_p1, board_p2;
    logic [3:0] board_pos;
    logic       board_illegal, board_full, turn, timeout_evt, match_done;
    logic [1:0] board_winner, match_winner;
    logic [3:0] p1_score, p2_score, draws;

    always #5 clk = ~clk;

    ttt_match_controller #(
        .WINS_TO_MATCH (WINS),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .TMR_W         (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .p1_req       (p1_req),
        .p1_req_pos   (p1_req_pos),
        .p2_req       (p2_req),
        .p2_req_pos   (p2_req_pos),
        .p1_ack       (p1_ack),
        .p2_ack       (p2_ack),
        .p1_nack      (p1_nack),
        .p2_nack      (p2_nack),
        .board_reset  (board_reset),
        .board_p1     (board_p1),
        .board_p2     (board_p2),
        .board_pos    (board_pos),
        .board_illegal(board_illegal),
        .board_winner (board_winner),
        .board_full   (board_full),
        .turn         (turn),
        .timeout_evt  (timeout_evt),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .draws        (draws),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    // Board cells are 2 bits each: 0 empty, 1 P1, 2 P2 (same code as the winner encoding).
    function automatic logic [1:0] line3(input logic [17:0] b, input int a, input int c, input int d);
        logic [1:0] x;
        x = b[2*a +: 2];
        if (x != 2'b00 && x == b[2*c +: 2] && x == b[2*d +: 2]) return x;
        return 2'b00;
    endfunction

    function automatic logic [1:0] winner_of(input logic [17:0] b);
        logic [1:0] w;
        w = 2'b00;
        for (int k = 0; k < 3; k++) begin
            if (w == 2'b00) w = line3(b, 3*k, 3*k+1, 3*k+2);
            if (w == 2'b00) w = line3(b, k, k+3, k+6);
        end
        if (w == 2'b00) w = line3(b, 0, 4, 8);
        if (w == 2'b00) w = line3(b, 2, 4, 6);
        return w;
    endfunction

    function automatic logic full_of(input logic [17:0] b);
        for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    logic [17:0] bcells = '0;

    always_comb begin
        board_illegal = 1'b0;
        if (board_p1 || board_p2) begin
            if (board_pos > 4'd8) board_illegal = 1'b1;
            else board_illegal = (bcells[2*board_pos +: 2] != 2'b00);
        end
    end

    assign board_winner = winner_of(bcells);
    assign board_full   = full_of(bcells);

    always @(posedge clk) begin
        if (board_reset) bcells <= '0;
        else if ((board_p1 ^ board_p2) && !board_illegal)
            bcells[2*board_pos +: 2] <= board_p1 ? 2'd1 : 2'd2;
    end

    typedef struct {
        int          cyc;
        logic [11:0] pulses;
        logic        chkTurn;
        logic        turn;
        logic [14:0] st;
    } exp_t;

    exp_t expq[$];
    int   nCmp = 0, nBad = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state of the match as the rules describe it.
    logic        mTurn = 1'b0, mDone = 1'b0;
    logic [3:0]  mS1 = 0, mS2 = 0, mDr = 0, mGame = 0, mPos = 0;
    logic [1:0]  mMw = 2'b00;
    logic [17:0] mCells = '0;
    int          mRem = TMO, stallLeft = 0;

    function automatic logic [11:0] mk(input logic p1a, input logic p2a, input logic p1n,
                                       input logic p2n, input logic br, input logic b1,
                                       input logic b2, input logic [3:0] pos, input logic to);
        return {p1a, p2a, p1n, p2n, br, b1, b2, pos, to};
    endfunction

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    task automatic pushExp(input logic [11:0] p, input logic chkTurn);
        exp_t e;
        e.cyc = cyc; e.pulses = p; e.chkTurn = chkTurn; e.turn = mTurn;
        e.st = {mS1, mS2, mDr, mDone, mMw};
        expq.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [11:0] obs;
        logic [14:0] st;
        obs = {p1_ack, p2_ack, p1_nack, p2_nack, board_reset, board_p1, board_p2, board_pos, timeout_evt};
        st  = {p1_score, p2_score, draws, match_done, match_winner};
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            nCmp++;
            if (obs !== e.pulses) begin
                nBad++;
                $display("[TB] FAIL pulses cyc=%0d got %b want %b", cyc, obs, e.pulses);
            end
            nCmp++;
            if (st !== e.st) begin
                nBad++;
                $display("[TB] FAIL status cyc=%0d got %h want %h", cyc, st, e.st);
            end
            if (e.chkTurn) begin
                nCmp++;
                if (turn !== e.turn) begin
                    nBad++;
                    $display("[TB] FAIL turn cyc=%0d got %b want %b", cyc, turn, e.turn);
                end
            end
        end else if (obs != 12'd0) begin
            nCmp++; nBad++;
            $display("[TB] FAIL unexpected_pulse cyc=%0d got %b want 0", cyc, obs);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic checkOutput(input string name);
        logic [31:0] all;
        @(negedge clk);
        all = {p1_ack, p2_ack, p1_nack, p2_nack, board_reset, board_p1, board_p2, board_pos, turn,
               timeout_evt, p1_score, p2_score, draws, match_done, match_winner};
        nCmp++;
        if (all !== 32'd0) begin
            nBad++;
            $display("[TB] FAIL %s outputs got %h want 0", name, all);
        end
        @(posedge clk); #1;
    endtask

    task automatic openGame();
        pushExp(mk(0, 0, 0, 0, 1, 0, 0, 4'd0, 0), 1'b0);
        mCells = '0; mTurn = mGame[0]; mRem = TMO;
        tick();
    endtask

    task automatic startMatch();
        start = 1'b1;
        mS1 = 0; mS2 = 0; mDr = 0; mMw = 2'b00; mDone = 1'b0; mGame = 0;
        tick();
        start = 1'b0;
        openGame();
    endtask

    // One WAIT_MOVE cycle with a random action; returns whether a move was accepted for issue.
    task automatic applyStimulus(output logic moved);
        int a, nEmpty;
        int empties[9];
        logic mreq, oreq, valid, to, n1, n2;
        logic [3:0] mpos, opos;
        mreq = 1'b0; oreq = 1'b0; to = 1'b0;
        mpos = 4'($urandom_range(0, 15)); opos = 4'($urandom_range(0, 15));
        a = $urandom_range(0, 99);
        if (stallLeft > 0) stallLeft--;
        else if (a < 4) stallLeft = 12;
        else if (a < 52) begin
            mreq = 1'b1; oreq = ($urandom_range(0, 4) == 0);
            nEmpty = 0;
            for (int i = 0; i < 9; i++) if (mCells[2*i +: 2] == 2'b00) begin empties[nEmpty] = i; nEmpty++; end
            if (nEmpty > 0 && $urandom_range(0, 9) < 7) mpos = 4'(empties[$urandom_range(0, nEmpty - 1)]);
            else mpos = 4'($urandom_range(0, 8));
        end else if (a < 82) oreq = 1'b1;
        else if (a < 92) begin mreq = 1'b1; mpos = 4'($urandom_range(9, 15)); end
        valid = mreq && (mpos <= 4'd8);
        if (!valid) begin
            if (mRem == 1) to = 1'b1;
            else mRem--;
        end
        {p1_req, p1_req_pos, p2_req, p2_req_pos} = mTurn ? {oreq, opos, mreq, mpos} : {mreq, mpos, oreq, opos};
        n1 = mTurn ? oreq : (mreq && !valid);
        n2 = mTurn ? (mreq && !valid) : oreq;
        if (n1 || n2 || to) pushExp(mk(0, 0, n1, n2, 0, 0, 0, 4'd0, to), 1'b1);
        if (to) begin mTurn = ~mTurn; mRem = TMO; end
        mPos = mpos;
        moved = valid;
        tick();
        p1_req = 1'b0; p2_req = 1'b0;
    endtask

    task automatic issueStep(output logic legal);
        legal = (mCells[2*mPos +: 2] == 2'b00);
        pushExp(mk(!mTurn && legal, mTurn && legal, !mTurn && !legal, mTurn && !legal,
                   0, !mTurn, mTurn, mPos, 0), 1'b1);
        if (legal) mCells[2*mPos +: 2] = mTurn ? 2'd2 : 2'd1;
        tick();
    endtask

    task automatic checkStep(output logic over);
        logic [1:0] w;
        w = winner_of(mCells);
        over = 1'b1;
        if (w == 2'b01) mS1 = satInc(mS1);
        else if (w == 2'b10) mS2 = satInc(mS2);
        else if (full_of(mCells)) mDr = satInc(mDr);
        else begin over = 1'b0; mTurn = ~mTurn; mRem = TMO; end
        tick();
    endtask

    task automatic playMatch(input int resetAtMove);
        logic moved, legal, over, matchEnd;
        int   moves;
        matchEnd = 1'b0; moves = 0;
        startMatch();
        while (!matchEnd) begin
            applyStimulus(moved);
            if (moved) begin
                moves++;
                if (moves == resetAtMove) begin
                    reset = 1'b1;
                    issueStep(legal);
                    checkOutput("reset_in_issue");
                    reset = 1'b0;
                    mS1 = 0; mS2 = 0; mDr = 0; mTurn = 1'b0; mMw = 2'b00; mDone = 1'b0;
                    tick();
                    return;
                end
                issueStep(legal);
                if (legal) begin
                    checkStep(over);
                    if (over) begin
                        repeat (GAP) tick();
                        if (mS1 == 4'(WINS)) begin mMw = 2'b01; mDone = 1'b1; matchEnd = 1'b1; end
                        else if (mS2 == 4'(WINS)) begin mMw = 2'b10; mDone = 1'b1; matchEnd = 1'b1; end
                        else begin mGame = mGame + 4'd1; openGame(); end
                    end
                end
            end
        end
        for (int k = 0; k < 6; k++) begin
            p1_req = 1'($urandom_range(0, 1)); p2_req = 1'($urandom_range(0, 1));
            p1_req_pos = 4'($urandom_range(0, 15)); p2_req_pos = 4'($urandom_range(0, 15));
            if (p1_req || p2_req) pushExp(mk(0, 0, p1_req, p2_req, 0, 0, 0, 4'd0, 0), 1'b1);
            tick();
        end
        p1_req = 1'b0; p2_req = 1'b0;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        nCmp++; nBad++;
        $display("[TB] FAIL watchdog got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        $display("[TB] start");
        repeat (3) tick();
        checkOutput("reset_state");
        reset = 1'b0;
        playMatch(0);
        playMatch(0);
        playMatch(7);
        playMatch(0);
        playMatch(0);
        repeat (3) tick();
        nCmp++;
        if (expq.size() != 0) begin
            nBad++;
            $display("[TB] FAIL leftover_expected got %0d want 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
